// File: rtl/dmem_be_ctrl_pkg.sv
// Shared definitions for the byte-enable data-memory controller.
// Holds funct3 encodings, FSM state type and the default RAM depth.
package dmem_be_ctrl_pkg;

    localparam int DATA_MEM_DEPTH = 1024;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LD  = 3'b011;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_LWU = 3'b110;

    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;
    localparam logic [2:0] FUNCT3_SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

endpackage

// File: rtl/dmem_be_ctrl_ram.sv
// Single-port read-first RAM with per-byte write enables.
// The read register only updates when en_i is high, so the last read is held.
module dmem_ram_be
    import dmem_be_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = DATA_MEM_DEPTH
) (
    input  logic                       clk,
    input  logic                       en_i,
    input  logic [DATA_WIDTH/8-1:0]    we_i,
    input  logic [$clog2(DEPTH)-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    output logic [DATA_WIDTH-1:0]      rdata_o
);

    localparam int NB = DATA_WIDTH / 8;

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem[addr_i];
            for (int i = 0; i < NB; i++) begin
                if (we_i[i]) begin
                    mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_be_ctrl.sv
// Data-memory controller: byte-lane steering, load extension, alignment
// checks and an optional wait-state FSM in front of a byte-enable RAM.
module dmem_be_ctrl
    import dmem_be_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = DATA_MEM_DEPTH,
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam bit IS64  = (DATA_WIDTH == 64);
    localparam logic [2:0] CNT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

    logic [OFF_W-1:0]      req_off;
    logic [IDX_W-1:0]      req_idx;
    logic                  accept;
    logic                  req_err;
    logic [NB-1:0]         be;
    logic [NB-1:0]         ram_we;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  unused_addr;

    dmem_state_e      state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             pend_err_q, pend_err_d;
    logic             pend_zero_q, pend_zero_d;
    logic [2:0]       pend_funct3_q, pend_funct3_d;
    logic [OFF_W-1:0] pend_off_q, pend_off_d;

    assign req_off     = req_addr_i[OFF_W-1:0];
    assign req_idx     = req_addr_i[OFF_W+IDX_W-1:OFF_W];
    assign unused_addr = ^req_addr_i;
    assign accept      = req_valid_i && ready_q && rst_n;

    always_comb begin
        req_err = 1'b0;
        if (req_we_i) begin
            case (req_funct3_i)
                FUNCT3_SB: req_err = 1'b0;
                FUNCT3_SH: req_err = req_off[0];
                FUNCT3_SW: req_err = (req_off[1:0] != 2'b00);
                FUNCT3_SD: req_err = !IS64 || (req_off != '0);
                default:   req_err = 1'b1;
            endcase
        end else begin
            case (req_funct3_i)
                FUNCT3_LB, FUNCT3_LBU: req_err = 1'b0;
                FUNCT3_LH, FUNCT3_LHU: req_err = req_off[0];
                FUNCT3_LW:             req_err = (req_off[1:0] != 2'b00);
                FUNCT3_LWU:            req_err = !IS64 || (req_off[1:0] != 2'b00);
                FUNCT3_LD:             req_err = !IS64 || (req_off != '0);
                default:               req_err = 1'b1;
            endcase
        end
    end

    // Store data is replicated so whichever lanes are enabled see the right bytes.
    always_comb begin
        be        = '0;
        wdata_rep = req_wdata_i;
        case (req_funct3_i[1:0])
            2'b00: begin
                be        = NB'(8'h01);
                wdata_rep = {NB{req_wdata_i[7:0]}};
            end
            2'b01: begin
                be        = NB'(8'h03);
                wdata_rep = {(NB/2){req_wdata_i[15:0]}};
            end
            2'b10: begin
                be        = NB'(8'h0F);
                wdata_rep = {(NB/4){req_wdata_i[31:0]}};
            end
            default: begin
                be        = NB'(8'hFF);
                wdata_rep = req_wdata_i;
            end
        endcase
    end

    assign ram_we = (be << req_off) & {NB{accept && req_we_i && !req_err}};

    dmem_ram_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .en_i    (accept),
        .we_i    (ram_we),
        .addr_i  (req_idx),
        .wdata_i (wdata_rep),
        .rdata_o (ram_rdata)
    );

    assign shifted = ram_rdata >> {pend_off_q, 3'b000};

    always_comb begin
        load_ext = '0;
        case (pend_funct3_q)
            FUNCT3_LB:  load_ext = DATA_WIDTH'($signed(shifted[7:0]));
            FUNCT3_LH:  load_ext = DATA_WIDTH'($signed(shifted[15:0]));
            FUNCT3_LW:  load_ext = DATA_WIDTH'($signed(shifted[31:0]));
            FUNCT3_LBU: load_ext = DATA_WIDTH'(shifted[7:0]);
            FUNCT3_LHU: load_ext = DATA_WIDTH'(shifted[15:0]);
            FUNCT3_LWU: load_ext = DATA_WIDTH'(shifted[31:0]);
            default:    load_ext = shifted;
        endcase
    end

    assign load_data = pend_zero_q ? '0 : load_ext;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        pend_err_d    = pend_err_q;
        pend_zero_d   = pend_zero_q;
        pend_funct3_d = pend_funct3_q;
        pend_off_d    = pend_off_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pend_err_d    = req_err;
                    pend_zero_d   = req_we_i || req_err;
                    pend_funct3_d = req_funct3_i;
                    pend_off_d    = req_off;
                    if (WAIT_CYCLES == 0) begin
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            ready_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            pend_err_q    <= 1'b0;
            pend_zero_q   <= 1'b1;
            pend_funct3_q <= 3'd0;
            pend_off_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ready_q       <= ready_d;
            rsp_valid_q   <= rsp_valid_d;
            pend_err_q    <= pend_err_d;
            pend_zero_q   <= pend_zero_d;
            pend_funct3_q <= pend_funct3_d;
            pend_off_q    <= pend_off_d;
        end
    end

    // Without wait states the pending registers already change only on a
    // response; with wait states they change at accept, so stage a copy.
    generate
        if (WAIT_CYCLES == 0) begin : g_direct
            assign rsp_rdata_o = load_data;
            assign rsp_err_o   = pend_err_q;
        end else begin : g_staged
            logic [DATA_WIDTH-1:0] rsp_rdata_q;
            logic                  rsp_err_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end else if (rsp_valid_d) begin
                    rsp_rdata_q <= load_data;
                    rsp_err_q   <= pend_err_q;
                end
            end
            assign rsp_rdata_o = rsp_rdata_q;
            assign rsp_err_o   = rsp_err_q;
        end
    endgenerate

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;

endmodule
